// File: rtl/i2s_tx.sv
// rtl/i2s_tx.sv - I2S transmitter: stereo pair buffer, SCK divider and frame serialiser
module i2s_tx #(
    parameter int DW      = 16,
    parameter int CLK_DIV = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ws_align,
    input  logic [DW-1:0] din_left,
    input  logic [DW-1:0] din_right,
    input  logic          din_valid,
    output logic          din_ready,
    output logic          i2s_clk,
    output logic          i2s_ws,
    output logic          i2s_dout,
    output logic          frame_start,
    output logic          underrun
);

    localparam int DCW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BCW = $clog2(2 * DW);

    localparam logic [DCW-1:0] DIV_LAST = DCW'(CLK_DIV - 1);
    localparam logic [DCW-1:0] DIV_ONE  = DCW'(1);
    localparam logic [BCW-1:0] BIT_LAST = BCW'(2 * DW - 1);
    localparam logic [BCW-1:0] BIT_ONE  = BCW'(1);
    localparam logic [BCW-1:0] BIT_HALF = BCW'(DW);
    localparam logic [BCW-1:0] BIT_PRE  = BCW'(DW - 1);

    logic [DCW-1:0]  divcnt;
    logic            sck;
    logic [BCW-1:0]  bitcnt;
    logic [2*DW-1:0] shift;
    logic            full;
    logic [DW-1:0]   buf_left;
    logic [DW-1:0]   buf_right;
    logic            mode;
    logic            ws_q;
    logic            frame_start_q;
    logic            underrun_q;

    logic            div_wrap;
    logic            fall_ev;
    logic            boundary;
    logic            xfer;
    logic [BCW-1:0]  bit_nxt;
    logic            mode_nxt;
    logic            ws_nxt;

    // Event decode and the bit position / format that the next SCK fall will present
    always_comb begin
        div_wrap = (divcnt == DIV_LAST);
        fall_ev  = div_wrap & sck;
        boundary = fall_ev & (bitcnt == BIT_LAST);
        xfer     = din_valid & ~full;
        bit_nxt  = boundary ? '0 : bitcnt + BIT_ONE;
        mode_nxt = boundary ? ws_align : mode;
        if (mode_nxt) begin
            ws_nxt = (bit_nxt >= BIT_HALF);
        end else begin
            ws_nxt = (bit_nxt >= BIT_PRE) & (bit_nxt != BIT_LAST);
        end
    end

    // Bit-clock divider: toggle SCK every CLK_DIV system clocks
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            divcnt <= '0;
            sck    <= 1'b0;
        end else begin
            divcnt <= div_wrap ? '0 : divcnt + DIV_ONE;
            if (div_wrap) begin
                sck <= ~sck;
            end
        end
    end

    // Serialiser: WS, data and bit position move only on SCK falls; frame load at the wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bitcnt        <= BIT_LAST;
            shift         <= '0;
            mode          <= 1'b0;
            ws_q          <= 1'b0;
            frame_start_q <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            frame_start_q <= boundary;
            underrun_q    <= boundary & ~full;
            if (fall_ev) begin
                bitcnt <= bit_nxt;
                ws_q   <= ws_nxt;
                if (boundary) begin
                    mode  <= ws_align;
                    shift <= full ? {buf_left, buf_right} : '0;
                end else begin
                    shift <= shift << 1;
                end
            end
        end
    end

    // Single-pair holding buffer; a pair arriving on an empty-buffer boundary waits for the next frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full      <= 1'b0;
            buf_left  <= '0;
            buf_right <= '0;
        end else if (xfer) begin
            full      <= 1'b1;
            buf_left  <= din_left;
            buf_right <= din_right;
        end else if (boundary) begin
            full <= 1'b0;
        end
    end

    assign din_ready   = ~full;
    assign i2s_clk     = sck;
    assign i2s_ws      = ws_q;
    assign i2s_dout    = shift[2*DW-1];
    assign frame_start = frame_start_q;
    assign underrun    = underrun_q;

endmodule

// File: tb/tb_i2s_tx.sv
// tb/tb_i2s_tx.sv - directed self-checking bench for i2s_tx
module tb_i2s_tx;

    localparam int DW      = 16;
    localparam int CLK_DIV = 4;
    localparam int FRAME   = 2 * DW * 2 * CLK_DIV;
    localparam logic [31:0] WS_I2S = 32'h0001_FFFE;
    localparam logic [31:0] WS_LJ  = 32'h0000_FFFF;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ws_align;
    logic [DW-1:0] din_left;
    logic [DW-1:0] din_right;
    logic          din_valid;
    logic          din_ready;
    logic          i2s_clk;
    logic          i2s_ws;
    logic          i2s_dout;
    logic          frame_start;
    logic          underrun;

    int            n_vec = 0;
    int            n_err = 0;
    logic          feed = 1'b0;
    logic          prev_ready = 1'b0;
    logic [15:0]   pk = '0;
    int            xfers = 0;
    int            low_cnt = 0;

    i2s_tx #(.DW(DW), .CLK_DIV(CLK_DIV)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ws_align    (ws_align),
        .din_left    (din_left),
        .din_right   (din_right),
        .din_valid   (din_valid),
        .din_ready   (din_ready),
        .i2s_clk     (i2s_clk),
        .i2s_ws      (i2s_ws),
        .i2s_dout    (i2s_dout),
        .frame_start (frame_start),
        .underrun    (underrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One system clock, sampled on the falling edge; optionally keeps din_valid high with an incrementing pair
    task automatic step();
        @(negedge clk);
        if (!din_ready) low_cnt++;
        if (feed && prev_ready && din_valid) begin
            xfers++;
            pk++;
            din_left  = 16'hC100 + pk;
            din_right = 16'hE200 + pk;
        end
        prev_ready = din_ready;
    endtask

    task automatic capture(output logic [31:0] d, output logic [31:0] w, output int period,
                           output logic ur, output int stray);
        int   guard = 0;
        int   n = 0;
        logic prev;
        d = '0; w = '0; period = 0; stray = 0; ur = 1'b0;
        while (!frame_start && guard < 2 * FRAME) begin
            step();
            guard++;
        end
        if (!frame_start) begin
            check("frame_start_timeout", {31'b0, frame_start}, 32'd1);
            return;
        end
        ur      = underrun;
        xfers   = 0;
        low_cnt = 0;
        prev    = i2s_clk;
        while (n < 32 && period < 2 * FRAME) begin
            step();
            period++;
            if (underrun) stray++;
            if (i2s_clk && !prev) begin
                d[31-n] = i2s_dout;
                w[31-n] = i2s_ws;
                n++;
            end
            prev = i2s_clk;
        end
        while (!frame_start && period < 2 * FRAME) begin
            step();
            period++;
            if (underrun && !frame_start) stray++;
        end
    endtask

    task automatic verify(input string tag, input logic [31:0] exp_d, input logic [31:0] exp_w,
                          input logic exp_ur);
        logic [31:0] d, w;
        int          period, stray;
        logic        ur;
        capture(d, w, period, ur, stray);
        check({tag, "_data"}, d, exp_d);
        check({tag, "_ws"}, w, exp_w);
        check({tag, "_period"}, period, FRAME);
        check({tag, "_underrun"}, {31'b0, ur}, {31'b0, exp_ur});
        check({tag, "_stray_underrun"}, stray, 0);
    endtask

    task automatic count_to_boundary(input string tag);
        int cnt = 0;
        while (!frame_start && cnt < 100) begin
            @(negedge clk);
            cnt++;
            if (cnt == 1 && din_valid) begin
                check({tag, "_ready_after_xfer"}, {31'b0, din_ready}, 32'd0);
                din_valid = 1'b0;
            end
            if (cnt == CLK_DIV - 1) check({tag, "_sck_before_rise"}, {31'b0, i2s_clk}, 32'd0);
            if (cnt == CLK_DIV) check({tag, "_first_rise"}, {31'b0, i2s_clk}, 32'd1);
        end
        check({tag, "_first_boundary_cycle"}, cnt, 2 * CLK_DIV);
        check({tag, "_ready_at_boundary"}, {31'b0, din_ready}, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; ws_align = 1'b0; din_valid = 1'b0; din_left = '0; din_right = '0;
        repeat (3) @(negedge clk);
        check("rst_sck", {31'b0, i2s_clk}, 32'd0);
        check("rst_ws", {31'b0, i2s_ws}, 32'd0);
        check("rst_dout", {31'b0, i2s_dout}, 32'd0);
        check("rst_ready", {31'b0, din_ready}, 32'd1);
        check("rst_frame_start", {31'b0, frame_start}, 32'd0);
        check("rst_underrun", {31'b0, underrun}, 32'd0);

        // Pair offered right after reset lands in the first frame
        rst_n = 1'b1; din_valid = 1'b1; din_left = 16'hA5C3; din_right = 16'h1234;
        count_to_boundary("start");
        check("start_dout_msb", {31'b0, i2s_dout}, 32'd1);
        check("start_underrun", {31'b0, underrun}, 32'd0);

        // Frame 1 in I2S; ws_align raised mid-frame and a second copy of the pair queued
        ws_align = 1'b1; din_valid = 1'b1;
        fork
            verify("f1_i2s", 32'hA5C3_1234, WS_I2S, 1'b0);
            begin
                @(negedge clk);
                check("f1_ready_low", {31'b0, din_ready}, 32'd0);
                din_valid = 1'b0;
            end
        join

        // Frame 2 left-justified; dropping ws_align mid-frame must not disturb it
        fork
            verify("f2_lj", 32'hA5C3_1234, WS_LJ, 1'b0);
            begin
                repeat (100) @(negedge clk);
                ws_align = 1'b0;
            end
        join

        verify("f3_zero", 32'h0, WS_I2S, 1'b1);

        // Pair presented first in the exact boundary cycle with the buffer empty
        repeat (FRAME - 1) @(negedge clk);
        din_valid = 1'b1; din_left = 16'h8001; din_right = 16'h7FFE;
        @(negedge clk);
        check("bnd_frame_start", {31'b0, frame_start}, 32'd1);
        check("bnd_underrun", {31'b0, underrun}, 32'd1);
        check("bnd_ready", {31'b0, din_ready}, 32'd0);
        din_valid = 1'b0;
        verify("f5_bnd_zero", 32'h0, WS_I2S, 1'b1);
        verify("f6_bnd_pair", 32'h8001_7FFE, WS_I2S, 1'b0);

        // Continuous offer: one transfer per frame, no skipped or repeated pairs
        pk = '0; din_left = 16'hC100; din_right = 16'hE200; din_valid = 1'b1;
        prev_ready = din_ready; feed = 1'b1;
        verify("f7_fill", 32'h0, WS_I2S, 1'b1);
        check("f7_xfers", xfers, 1);
        check("f7_ready_low", low_cnt, FRAME - 1);
        for (int k = 0; k < 3; k++) begin
            logic [15:0] l, r;
            l = 16'hC100 + 16'(k);
            r = 16'hE200 + 16'(k);
            verify($sformatf("stream%0d", k), {l, r}, WS_I2S, 1'b0);
            check($sformatf("stream%0d_xfers", k), xfers, 1);
            check($sformatf("stream%0d_ready_low", k), low_cnt, FRAME - 1);
        end
        feed = 1'b0;

        // Buffer a further pair, then reset in the right-channel half of frame 11
        @(negedge clk);
        check("pre_rst_ready", {31'b0, din_ready}, 32'd0);
        din_valid = 1'b0;
        repeat (132) @(negedge clk);
        check("pre_rst_sck", {31'b0, i2s_clk}, 32'd1);
        check("pre_rst_ws", {31'b0, i2s_ws}, 32'd1);
        check("pre_rst_dout", {31'b0, i2s_dout}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("arst_sck", {31'b0, i2s_clk}, 32'd0);
        check("arst_ws", {31'b0, i2s_ws}, 32'd0);
        check("arst_dout", {31'b0, i2s_dout}, 32'd0);
        check("arst_ready", {31'b0, din_ready}, 32'd1);
        check("arst_frame_start", {31'b0, frame_start}, 32'd0);
        check("arst_underrun", {31'b0, underrun}, 32'd0);

        // After reset the discarded pair must not reappear
        @(negedge clk);
        rst_n = 1'b1;
        count_to_boundary("restart");
        check("restart_underrun", {31'b0, underrun}, 32'd1);
        verify("post_rst", 32'h0, WS_I2S, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
